// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and engine state encoding
// for the memory-mapped UART.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_TX_BUSY      = 2;
    localparam int ST_RX_VALID     = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_RX_FRAME_ERR = 5;

    localparam int CTRL_RX_IE = 16;
    localparam int CTRL_TX_IE = 17;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// Simple chip-select bus between the address decoder (master) and the UART (slave).
interface uart_mmio_if;
    logic        cs_n;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs_n, output we, output addr, output wdata, input rdata);
    modport slave  (input cs_n, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count; push is refused when full
// regardless of a same-cycle pop.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO + serializer, RX deserializer with overrun/framing
// flags, programmable baud divisor latched per bit by each engine.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int TX_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    uart_mmio_if.slave  bus,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        irq
);
    localparam int          DIV0_I = CLOCK_FREQ / BAUD_RATE;
    localparam logic [15:0] DIV0   = 16'(DIV0_I);

    function automatic logic [15:0] sat_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    logic        w_rd, w_tx_wr, w_rx_pop, w_status_wr, w_ctrl_wr;
    logic [31:0] w_rd_data;
    logic        w_unused;

    logic [15:0] r_div;
    logic        r_rx_ie, r_tx_ie;
    logic [31:0] r_rdata;

    logic        w_fifo_pop, w_fifo_full, w_fifo_empty;
    logic [7:0]  w_fifo_dout;

    uart_state_t r_tx_state;
    logic [15:0] r_tx_cnt, r_tx_bdiv;
    logic [2:0]  r_tx_bitidx;
    logic [7:0]  r_tx_shift;
    logic        r_txd, w_tx_tick, w_tx_busy;

    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_t r_rx_state;
    logic [15:0] r_rx_cnt, r_rx_bdiv;
    logic [2:0]  r_rx_bitidx;
    logic [7:0]  r_rx_shift, r_rx_byte;
    logic        r_rx_valid, r_rx_ov, r_rx_fe;
    logic        w_rx_tick, w_rx_half, w_rx_good, w_rx_bad, w_rx_load;

    assign w_rd        = !bus.cs_n && !bus.we;
    assign w_tx_wr     = !bus.cs_n && bus.we && (bus.addr[3:2] == REG_TXDATA);
    assign w_status_wr = !bus.cs_n && bus.we && (bus.addr[3:2] == REG_STATUS);
    assign w_ctrl_wr   = !bus.cs_n && bus.we && (bus.addr[3:2] == REG_CTRL);
    assign w_rx_pop    = w_rd && (bus.addr[3:2] == REG_RXDATA);
    assign w_unused    = ^{bus.addr[11:4], bus.addr[1:0], bus.wdata[31:18]};

    uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_wr),
        .i_din   (bus.wdata[7:0]),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // TX engine: each bit lasts r_tx_bdiv clocks, re-latched from r_div at every bit start
    assign w_tx_tick  = (r_tx_cnt == r_tx_bdiv - 16'd1);
    assign w_tx_busy  = (r_tx_state != S_IDLE);
    assign w_fifo_pop = !w_fifo_empty &&
                        ((r_tx_state == S_IDLE) || (r_tx_state == S_STOP && w_tx_tick));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state  <= S_IDLE;
            r_txd       <= 1'b1;
            r_tx_cnt    <= '0;
            r_tx_bdiv   <= DIV0;
            r_tx_bitidx <= '0;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_tx_state <= S_START;
                        r_txd      <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_bdiv  <= r_div;
                    end
                end
                S_START: begin
                    if (w_tx_tick) begin
                        r_tx_state  <= S_DATA;
                        r_txd       <= r_tx_shift[0];
                        r_tx_cnt    <= '0;
                        r_tx_bdiv   <= r_div;
                        r_tx_bitidx <= '0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt  <= '0;
                        r_tx_bdiv <= r_div;
                        if (r_tx_bitidx == 3'd7) begin
                            r_tx_state <= S_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bitidx <= r_tx_bitidx + 3'd1;
                            r_txd       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt  <= '0;
                        r_tx_bdiv <= r_div;
                        if (!w_fifo_empty) begin
                            r_tx_state <= S_START;
                            r_txd      <= 1'b0;
                        end else begin
                            r_tx_state <= S_IDLE;
                            r_txd      <= 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_pop)
            r_tx_shift <= w_fifo_dout;
        else if (r_tx_state == S_DATA && w_tx_tick)
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    end

    // RX engine: detection already trails the line by one clock, so the count starts at 1
    assign w_rx_tick = (r_rx_cnt == r_rx_bdiv - 16'd1);
    assign w_rx_half = (r_rx_cnt == {1'b0, r_rx_bdiv[15:1]} - 16'd1);
    assign w_rx_good = (r_rx_state == S_STOP) && w_rx_tick && r_rx_s2;
    assign w_rx_bad  = (r_rx_state == S_STOP) && w_rx_tick && !r_rx_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= S_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bdiv   <= DIV0;
            r_rx_bitidx <= '0;
        end else begin
            r_rx_s1   <= uart_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            case (r_rx_state)
                S_IDLE: begin
                    if (!r_rx_s2 && r_rx_prev) begin
                        r_rx_state  <= S_START;
                        r_rx_cnt    <= 16'd1;
                        r_rx_bdiv   <= r_div;
                        r_rx_bitidx <= '0;
                    end
                end
                S_START: begin
                    if (w_rx_half) begin
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                        r_rx_cnt   <= '0;
                        r_rx_bdiv  <= r_div;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt    <= '0;
                        r_rx_bdiv   <= r_div;
                        r_rx_bitidx <= r_rx_bitidx + 3'd1;
                        if (r_rx_bitidx == 3'd7) r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_state <= S_IDLE;
                        r_rx_cnt   <= '0;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_rx_state == S_DATA && w_rx_tick)
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end

    // A pop in the completion cycle frees the holding register for the new byte
    assign w_rx_load = w_rx_good && (!r_rx_valid || w_rx_pop);

    always_ff @(posedge clk) begin
        if (w_rx_load) r_rx_byte <= r_rx_shift;
    end

    always_comb begin
        w_rd_data = '0;
        case (bus.addr[3:2])
            REG_RXDATA: w_rd_data = {24'b0, r_rx_byte};
            REG_STATUS: begin
                w_rd_data[ST_TX_EMPTY]     = w_fifo_empty;
                w_rd_data[ST_TX_FULL]      = w_fifo_full;
                w_rd_data[ST_TX_BUSY]      = w_tx_busy;
                w_rd_data[ST_RX_VALID]     = r_rx_valid;
                w_rd_data[ST_RX_OVERRUN]   = r_rx_ov;
                w_rd_data[ST_RX_FRAME_ERR] = r_rx_fe;
            end
            REG_CTRL:   w_rd_data = {14'b0, r_tx_ie, r_rx_ie, r_div};
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= DIV0;
            r_rx_ie    <= 1'b0;
            r_tx_ie    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_ov    <= 1'b0;
            r_rx_fe    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_rd) r_rdata <= w_rd_data;
            if (w_ctrl_wr) begin
                r_div   <= sat_div(bus.wdata[15:0]);
                r_rx_ie <= bus.wdata[CTRL_RX_IE];
                r_tx_ie <= bus.wdata[CTRL_TX_IE];
            end
            if (w_rx_load)     r_rx_valid <= 1'b1;
            else if (w_rx_pop) r_rx_valid <= 1'b0;
            if (w_rx_good && r_rx_valid && !w_rx_pop)
                r_rx_ov <= 1'b1;
            else if (w_status_wr && bus.wdata[ST_RX_OVERRUN])
                r_rx_ov <= 1'b0;
            if (w_rx_bad)
                r_rx_fe <= 1'b1;
            else if (w_status_wr && bus.wdata[ST_RX_FRAME_ERR])
                r_rx_fe <= 1'b0;
        end
    end

    assign bus.rdata = r_rdata;
    assign uart_txd  = r_txd;
    assign irq       = (r_rx_valid && r_rx_ie) || (w_fifo_empty && r_tx_ie);

endmodule
